// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave with eight 32-bit registers.
// Registers 0..6 are read/write with byte strobes. Register 7 is a read-only ID.
// Addresses at or above 0x20 return SLVERR.
// Register 0 is also driven out on CTRL0 for the surrounding fabric.
//
// Handshake semantics (every channel): a transfer happens on a rising edge
// where VALID and READY are both 1. Once VALID is raised, it stays high until
// that edge, and its payload does not change until then. READY may be
// computed from state, but never from the same channel's VALID. While a
// response is pending, BRESP/RDATA/RRESP stay constant until the handshake.
//
// wr_state / rd_state expose the two FSM states for checkers.
module axi_lite_reg_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] ID_VALUE   = 32'hDEADBEEF
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [31:0]           CTRL0,
    output logic [1:0]            wr_state,
    output logic                  rd_state
);

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Low during the cycle after a reset edge, so the ready outputs stay low then.
    logic live;

    logic aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [31:0]           eff_data;
    logic [3:0]            eff_strb;
    logic [2:0]            wr_idx, rd_idx;
    logic                  wr_oor, wr_err, rd_oor;
    logic [31:0]           rd_val;
    logic [31:0]           regs [0:6];
    logic                  unused_addr_lsbs;

    // Byte lane bits [1:0] of both addresses carry no meaning here.
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0], awaddr_q[1:0]};

    // Tracks whether the block has been out of reset for at least one edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) live <= 1'b0;
        else          live <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write channel ready/valid outputs, decoded from the current state.
    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (w_state)
            W_IDLE:      begin AWREADY = live; WREADY = live; end
            W_HAVE_ADDR: WREADY  = 1'b1;
            W_HAVE_DATA: AWREADY = 1'b1;
            W_RESP:      BVALID  = 1'b1;
            default:     ;
        endcase
    end

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Write FSM next state. commit marks the edge that moves into W_RESP.
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Hold whichever half of the write (address or data) arrives first.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) awaddr_q <= AWADDR;
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
        end
    end

    // On the commit edge, one half may come from the bus and the other from the hold registers.
    assign eff_addr = aw_hs ? AWADDR : awaddr_q;
    assign eff_data = w_hs  ? WDATA  : wdata_q;
    assign eff_strb = w_hs  ? WSTRB  : wstrb_q;
    assign wr_idx   = eff_addr[4:2];
    assign wr_oor   = |eff_addr[ADDR_WIDTH-1:5];
    assign wr_err   = wr_oor || (wr_idx == 3'd7);

    // Register file write. Only the strobed bytes change; reset takes priority over a commit.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < 7; i++) regs[i] <= '0;
        end else if (commit && !wr_err) begin
            for (int i = 0; i < 7; i++) begin
                if (wr_idx == 3'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (eff_strb[b]) regs[i][8*b +: 8] <= eff_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Write response is decided at commit and then held until BREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETn)    BRESP <= RESP_OKAY;
        else if (commit) BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read channel ready/valid outputs, decoded from the current state.
    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_state)
            R_IDLE:  ARREADY = live;
            R_DATA:  RVALID  = 1'b1;
            default: ;
        endcase
    end

    assign ar_hs = ARVALID && ARREADY;

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)  r_next = R_DATA;
            R_DATA:  if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign rd_idx = ARADDR[4:2];
    assign rd_oor = |ARADDR[ADDR_WIDTH-1:5];

    // Read mux. It sees register values from before any write committing on this same edge.
    always_comb begin
        rd_val = '0;
        if (!rd_oor) begin
            if (rd_idx == 3'd7) begin
                rd_val = ID_VALUE;
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (rd_idx == 3'(i)) rd_val = regs[i];
                end
            end
        end
    end

    // Read data and response are captured on the AR handshake and held until RREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            RDATA <= rd_val;
            RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign CTRL0    = regs[0];
    assign wr_state = w_state;
    assign rd_state = r_state;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed and random bench for axi_lite_reg_responder.
// Expected values come from a register-map model based on the address rules.
module tb_axi_lite_reg_responder;

  localparam int AW = 12;
  localparam logic [31:0] ID = 32'hDEADBEEF;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic [31:0]   CTRL0;
  logic [1:0]    wr_state;
  logic          rd_state;

  int checks = 0;
  int fails  = 0;
  logic [31:0] mdl [0:7];

  axi_lite_reg_responder #(.ADDR_WIDTH(AW), .ID_VALUE(ID)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .CTRL0(CTRL0), .wr_state(wr_state), .rd_state(rd_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx;
    if (a >= 32) return 2'b10;
    idx = int'(a) / 4;
    if (idx == 7) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [AW-1:0] a);
    int idx;
    if (a >= 32) return {2'b10, 32'h0};
    idx = int'(a) / 4;
    if (idx == 7) return {2'b00, ID};
    return {2'b00, mdl[idx]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
  endtask

  // drivers
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_done;
    bit w_done;
    int n;
    aw_done = 0;
    w_done = 0;
    n = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      tick();
      n++;
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("write_handshake_in_time", 32'(n < 20), 32'd1);
    check("bvalid_one_cycle_after", 32'(BVALID), 32'd1);
    resp = BRESP;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_drops", 32'(BVALID), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    ARADDR = a;
    ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready_in_time", 32'(n < 20), 32'd1);
    tick();
    ARVALID = 1'b0;
    check("rvalid_one_cycle_after", 32'(RVALID), 32'd1);
    d = RDATA;
    resp = RRESP;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_drops", 32'(RVALID), 32'd0);
  endtask

  task automatic write_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [1:0] r;
    logic [1:0] e;
    e = model_write(a, d, s);
    do_write(a, d, s, r);
    check(tag, 32'(r), 32'(e));
    check("ctrl0_tracks_reg0", CTRL0, mdl[0]);
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a);
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] e;
    e = model_read(a);
    do_read(a, d, r);
    check({tag, "_data"}, d, e[31:0]);
    check({tag, "_resp"}, 32'(r), 32'(e[33:32]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(AWREADY), 32'd0);
    check({tag, "_wready"},  32'(WREADY),  32'd0);
    check({tag, "_arready"}, 32'(ARREADY), 32'd0);
    check({tag, "_bvalid"},  32'(BVALID),  32'd0);
    check({tag, "_rvalid"},  32'(RVALID),  32'd0);
    check({tag, "_bresp"},   32'(BRESP),   32'd0);
    check({tag, "_rresp"},   32'(RRESP),   32'd0);
    check({tag, "_rdata"},   RDATA,        32'd0);
    check({tag, "_ctrl0"},   CTRL0,        32'd0);
  endtask

  // directed sequence, then random traffic, then a mid-transaction reset
  initial begin
    logic [31:0] held_data;
    logic [31:0] old_val;
    logic [1:0]  held_resp;
    logic [1:0]  dummy_r;
    logic [AW-1:0] ra;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    tick();
    check("ready_after_reset_aw", 32'(AWREADY), 32'd1);
    check("ready_after_reset_w",  32'(WREADY),  32'd1);
    check("ready_after_reset_ar", 32'(ARREADY), 32'd1);

    // full-word write and readback of register 0
    write_chk("wr0_resp", 12'h000, 32'hDEADBEEF, 4'hF);
    read_chk("rd0", 12'h000);
    check("ctrl0_deadbeef", CTRL0, 32'hDEADBEEF);

    // byte-strobed write to register 1
    write_chk("wr1_init", 12'h004, 32'h11223344, 4'hF);
    write_chk("wr1_strb", 12'h004, 32'hAABBCCDD, 4'b0101);
    read_chk("rd1_strb", 12'h004);
    check("rd1_literal", mdl[1], 32'h11BB33DD);

    // W arrives three cycles before AW, then BREADY is held low for five cycles
    WDATA = 32'hCAFE0808; WSTRB = 4'hF; WVALID = 1'b1;
    check("w_first_wready", 32'(WREADY), 32'd1);
    tick();
    WVALID = 1'b0;
    check("w_first_awready_wait", 32'(AWREADY), 32'd1);
    check("w_first_wready_drop", 32'(WREADY), 32'd0);
    repeat (2) tick();
    check("w_first_no_bvalid", 32'(BVALID), 32'd0);
    AWADDR = 12'h008; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    held_resp = model_write(12'h008, 32'hCAFE0808, 4'hF);
    check("w_first_bvalid_latency", 32'(BVALID), 32'd1);
    check("w_first_bresp", 32'(BRESP), 32'(held_resp));
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", 32'(BVALID), 32'd1);
      check("hold_bresp", 32'(BRESP), 32'(held_resp));
      check("hold_awready", 32'(AWREADY), 32'd0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("hold_bvalid_release", 32'(BVALID), 32'd0);
    read_chk("rd2", 12'h008);

    // read-only ID register and an out-of-range address
    write_chk("wr_id_slverr", 12'h01C, 32'h12345678, 4'hF);
    write_chk("wr_oor_slverr", 12'h040, 32'h87654321, 4'hF);
    read_chk("rd_oor", 12'h040);
    read_chk("rd_id", 12'h01C);

    // AR handshake on the same edge as a write commit returns the old value
    write_chk("wr3_init", 12'h00C, 32'h0BADF00D, 4'hF);
    old_val = mdl[3];
    AWADDR = 12'h00C; WDATA = 32'h600DCAFE; WSTRB = 4'hF;
    ARADDR = 12'h00C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    dummy_r = model_write(12'h00C, 32'h600DCAFE, 4'hF);
    check("same_edge_rvalid", 32'(RVALID), 32'd1);
    check("same_edge_bvalid", 32'(BVALID), 32'd1);
    check("same_edge_old_data", RDATA, old_val);
    check("same_edge_bresp", 32'(BRESP), 32'(dummy_r));
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    read_chk("rd3_new", 12'h00C);

    // random traffic, mixing in- and out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom_range(32, 4095));
      else ra = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) write_chk("rnd_wr", ra, $urandom, 4'($urandom_range(0, 15)));
      else read_chk("rnd_rd", ra);
    end

    // reset between the AW and W handshakes abandons the write
    write_chk("wr4_init", 12'h010, 32'h44444444, 4'hF);
    AWADDR = 12'h010; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WDATA = 32'h99999999; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    WVALID = 1'b0;
    model_reset();
    check_reset_outputs("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_reset_no_bvalid", 32'(BVALID), 32'd0);
    end
    check("mid_reset_awready_back", 32'(AWREADY), 32'd1);
    read_chk("rd4_after_reset", 12'h010);
    read_chk("rd0_after_reset", 12'h000);
    do_read(12'h01C, held_data, held_resp);
    check("id_after_reset", held_data, ID);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_responder.md
AXI_LITE_REG_RESPONDER -- requirements
Module: axi_lite_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: AXI4-Lite address width in bits.
REQ-002 SHALL have parameter ID_VALUE, default 32'hDEADBEEF: constant returned by read-only register 7.
REQ-003 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETn  in  1  synchronous, active-low reset.
REQ-004 SHALL have the following write-channel ports.
- AWADDR  in  ADDR_WIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
REQ-005 SHALL have the following read-channel ports.
- ARADDR  in  ADDR_WIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  32  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
REQ-006 SHALL have the following fabric port.
- CTRL0  out  32  continuous copy of register 0

Function
REQ-007 SHALL implement 8 x 32-bit registers at byte offsets 0x00..0x1C; index = ADDR[4:2]; ADDR[1:0] ignored.
REQ-008 SHALL treat any address >= 0x20 as out of range.
- Writes: no state change, BRESP=2'b10 (SLVERR).
- Reads: RDATA=0, RRESP=2'b10.
REQ-009 Registers 0..6 SHALL be read/write; register 7 SHALL be read-only and return ID_VALUE; a write to it SHALL return SLVERR with no effect.
REQ-010 A write SHALL update only bytes whose WSTRB bit is 1; WSTRB=0 SHALL give OKAY with no change.
REQ-011 Write FSM states SHALL be W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
- AWREADY=1 only in W_IDLE and W_HAVE_DATA.
- WREADY=1 only in W_IDLE and W_HAVE_ADDR.
REQ-012 Write FSM transitions SHALL be as follows.
- W_IDLE: AW only -> W_HAVE_ADDR; W only -> W_HAVE_DATA; both in same cycle -> W_RESP.
- W_HAVE_ADDR + W handshake -> W_RESP.
- W_HAVE_DATA + AW handshake -> W_RESP.
- W_RESP: BVALID=1; on BVALID&&BREADY -> W_IDLE.
REQ-013 The register write SHALL commit on the clock edge entering W_RESP; BVALID SHALL assert the following cycle, i.e. 1-cycle latency from the last of AW/W.
REQ-014 BRESP SHALL be stable and BVALID SHALL remain 1 until BREADY; at most one write SHALL be outstanding.
REQ-015 Read FSM states SHALL be R_IDLE and R_DATA.
- ARREADY=1 only in R_IDLE; AR handshake -> R_DATA.
- RVALID=1 in R_DATA; RVALID&&RREADY -> R_IDLE.
REQ-016 RDATA/RRESP SHALL be sampled on the AR handshake edge (1-cycle latency) and held stable until RREADY.
REQ-017 An AR handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-018 Read and write channels SHALL operate concurrently and independently.
REQ-019 CTRL0 SHALL update on the edge the write to register 0 commits.

Reset
REQ-020 While ARESETn=0 at a rising edge, the block SHALL do all of the following.
- Registers 0..6 <= 0; CTRL0 <= 0.
- FSMs <= W_IDLE/R_IDLE.
- BVALID, RVALID <= 0; BRESP, RRESP <= 0; RDATA <= 0.
- AWREADY, WREADY, ARREADY <= 0.
REQ-021 Ready outputs SHALL assert the first cycle after ARESETn returns to 1.
REQ-022 Reset mid-transaction SHALL abandon the transaction: no register update, no response issued.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- Write 32'hDEADBEEF to 0x00 with WSTRB=4'hF, then read 0x00 -> BRESP=OKAY; RDATA=32'hDEADBEEF, RRESP=OKAY; CTRL0=32'hDEADBEEF.
- Reg 1 = 32'h11223344, write 32'hAABBCCDD with WSTRB=4'b0101 -> read 32'h11BB33DD.
- W presented 3 cycles before AW to 0x08 -> WREADY handshake first; BVALID exactly 1 cycle after AW handshake.
- BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY=0 throughout.
- Write to 0x1C, then to 0x40, then read 0x40 -> SLVERR on both writes; read returns RDATA=0, RRESP=SLVERR; read 0x1C -> 32'hDEADBEEF, OKAY.
- ARESETn=0 for 1 cycle between AW and W handshakes -> all outputs at reset values; register unchanged; no BVALID.
